bus_seq_fetcher: RTL and testbench
==================================

# bus_seq_fetcher

Parametrised command fetcher for the bus sequencer. It walks the sequence ROM from a start address and resolves control words (NOP, JUMP, END) locally. Bus commands are buffered in a small prefetch FIFO and handed to the protocol engine (I2C/SPI back-end) over a valid/ready handshake. Unlike the earlier single-word reader, it pipelines ROM reads, follows jumps, detects address overrun and supports abort.

## Interface
Parameters:
- ROM_DATA_WIDTH, 13: ROM word width; opcode is the top 3 bits, argument is the remaining ROM_DATA_WIDTH-3 bits; must be ≥ ROM_ADDR_WIDTH+3.
- ROM_ADDR_WIDTH, 8: ROM address width.
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥ 2.
- BUS_TYPE, "I2C": passed through to package-level checks only; no behavioural effect here.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start a sequence; sampled only while ready_o=1.
- start_addr_i  in  ROM_ADDR_WIDTH  first word address.
- abort_i  in  1  abandon the running sequence.
- ready_o  out  1  idle, accepts start_i.
- done_o  out  1  one-cycle pulse: END reached and all commands consumed.
- error_o  out  1  sticky address overrun flag, cleared by the next accepted start.
- rom_rden_o  out  1  ROM read enable.
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM address.
- rom_data_i  in  ROM_DATA_WIDTH  ROM data, valid exactly 1 cycle after rom_rden_o.
- cmd_valid_o  out  1  command available.
- cmd_op_o  out  3  command opcode.
- cmd_arg_o  out  ROM_DATA_WIDTH-3  command argument.
- cmd_ready_i  in  1  engine accepts the command.

## Operation
- Opcodes:
  - 0 NOP: dropped.
  - 1 WRITE, 2 READ, 3 START, 4 STOP, 5 DELAY: pushed to the FIFO.
  - 6 JUMP: the target is arg[ROM_ADDR_WIDTH-1:0].
  - 7 END: ends the sequence.
- States:
  - IDLE: ready_o=1. An accepted start_i loads the fetch pointer, clears error_o and moves to FETCH.
  - FETCH: issues reads and decodes returned words.
  - DRAIN: no reads are issued. When the FIFO is empty, done_o pulses and the block returns to IDLE.
- Read issue in FETCH requires count + inflight < FIFO_DEPTH. A pop in the same cycle is not credited. At most one read per cycle; the pointer increments after each issue.
- The returned word is decoded in the cycle it arrives; its address is tracked in a registered copy.
  - JUMP: squash any read issued this cycle or still in flight (its data is discarded); load the pointer with the target.
  - END: squash, go to DRAIN.
- Overrun: a word from address 2^ROM_ADDR_WIDTH-1 that is not JUMP or END sets error_o, flushes the FIFO and squashes reads. The block returns to IDLE with no done_o. The pointer never wraps silently.
- abort_i in FETCH or DRAIN: flush the FIFO, squash in-flight reads, go to IDLE next cycle, no done_o, error_o unchanged. abort_i has priority over all other events; it is ignored in IDLE.
- start_i outside IDLE is ignored.
- cmd_* follows AXI-style rules: a transfer occurs when cmd_valid_o && cmd_ready_i. Once asserted, cmd_valid_o and the payload hold until accepted, except on a flush.
- A FIFO push and pop in the same cycle are both honoured.

## Timing
- Reset values: ready_o=1, all other outputs 0, state IDLE, FIFO empty, no reads in flight.
- Start accepted at edge 0. rom_rden_o=1 with rom_addr_o=start_addr_i in cycle 1. Data arrives in cycle 2; cmd_valid_o rises in cycle 3.
- Sustained throughput is 1 command/cycle with cmd_ready_i held high and no JUMPs.
- JUMP decoded in cycle n: the read at the target is issued in cycle n+1, giving a 1-bubble penalty.
- END decoded with an empty FIFO: done_o pulses in cycle n+1 and ready_o=1 in cycle n+2.
- rom_addr_o holds its last value when rom_rden_o=0.

## Structure
- Package bus_seq_pkg holds:
  - the opcode enum (opcode_e, 3 bits) and OPC_W=3;
  - the word_ut union (opcode/arg view versus raw view) for the default 13-bit width;
  - the state enum.
- Sub-module bus_seq_cmd_fifo is a synchronous FIFO with parameters WIDTH and DEPTH. It provides push, pop, flush, count, and a first-word-fall-through head.

## Test plan
- ROM[0x10..0x13] = START, WRITE 0xA5, STOP, END; start at 0x10 with cmd_ready_i=1 → 3 commands in cycles 3, 4, 5; done_o pulses once; no rden at 0x14.
- ROM[0x20] = JUMP 0x40, ROM[0x21] = WRITE 0x11, ROM[0x40] = WRITE 0x22, ROM[0x41] = END → only WRITE 0x22 is delivered; the 0x21 data is discarded.
- Engine stalls (cmd_ready_i=0) over 10 commands with FIFO_DEPTH=4 → count never exceeds 4; order and payloads intact after release.
- Sequence of WRITEs running to 0xFF without END → error_o=1, FIFO flushed, ready_o=1, no done_o; the next start clears error_o.
- abort_i asserted while 3 commands are queued and a read is in flight → cmd_valid_o=0 and ready_o=1 next cycle; no done_o.
- NOP-only words followed by END → no cmd_valid_o; done_o pulses.

Source files
------------

// File: rtl/bus_seq_fetcher_pkg.sv
// Shared types for the bus sequencer fetcher: opcodes, ROM word view, FSM states
// and an elaboration-time parameter sanity helper.
package bus_seq_pkg;

   localparam int unsigned OPC_W      = 3;
   localparam int unsigned WORD_W_DEF = 13;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP   = 3'd0,
      OP_WRITE = 3'd1,
      OP_READ  = 3'd2,
      OP_START = 3'd3,
      OP_STOP  = 3'd4,
      OP_DELAY = 3'd5,
      OP_JUMP  = 3'd6,
      OP_END   = 3'd7
   } opcode_e;

   typedef union packed {
      struct packed {
         opcode_e                         op;
         logic [WORD_W_DEF-OPC_W-1:0]     arg;
      } f;
      logic [WORD_W_DEF-1:0] raw;
   } word_ut;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   function automatic bit params_ok(input int unsigned dw, input int unsigned aw,
                                    input int unsigned depth);
      return (dw >= aw + OPC_W) && (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/bus_seq_fetcher_if.sv
// ROM read port and command handshake between the fetcher (master) and the
// ROM / protocol engine side (slave).
interface bus_seq_fetcher_if
   import bus_seq_pkg::*;
#(
   parameter int unsigned ROM_DATA_WIDTH = 13,
   parameter int unsigned ROM_ADDR_WIDTH = 8
);
   localparam int unsigned ARG_W = ROM_DATA_WIDTH - OPC_W;

   logic                      rom_rden_o;
   logic [ROM_ADDR_WIDTH-1:0] rom_addr_o;
   logic [ROM_DATA_WIDTH-1:0] rom_data_i;
   logic                      cmd_valid_o;
   logic [OPC_W-1:0]          cmd_op_o;
   logic [ARG_W-1:0]          cmd_arg_o;
   logic                      cmd_ready_i;

   modport master (
      output rom_rden_o, rom_addr_o, cmd_valid_o, cmd_op_o, cmd_arg_o,
      input  rom_data_i, cmd_ready_i
   );

   modport slave (
      input  rom_rden_o, rom_addr_o, cmd_valid_o, cmd_op_o, cmd_arg_o,
      output rom_data_i, cmd_ready_i
   );
endinterface

// File: rtl/bus_seq_fetcher_cmd_fifo.sv
// Synchronous FIFO with first-word-fall-through head, flush and occupancy count.
module bus_seq_cmd_fifo #(
   parameter int unsigned WIDTH = 13,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);
   localparam int unsigned PW     = $clog2(DEPTH);
   localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [PW:0]      cnt_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != FULL_C) || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bus_seq_fetcher.sv
// Sequence ROM walker: pipelined reads, local JUMP/END/NOP handling, command
// prefetch FIFO towards the protocol engine, overrun detection and abort.
module bus_seq_fetcher
   import bus_seq_pkg::*;
#(
   parameter int unsigned ROM_DATA_WIDTH = 13,
   parameter int unsigned ROM_ADDR_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter              BUS_TYPE       = "I2C"
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [ROM_ADDR_WIDTH-1:0] start_addr_i,
   input  logic                      abort_i,
   output logic                      ready_o,
   output logic                      done_o,
   output logic                      error_o,
   bus_seq_fetcher_if.master         bus_if
);
   localparam int unsigned ARG_W = ROM_DATA_WIDTH - OPC_W;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0]                ST_IDLE  = S_IDLE;
   localparam logic [1:0]                ST_FETCH = S_FETCH;
   localparam logic [1:0]                ST_DRAIN = S_DRAIN;
   localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [CNT_W:0]            DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);

   if (!params_ok(ROM_DATA_WIDTH, ROM_ADDR_WIDTH, FIFO_DEPTH) ||
       !((BUS_TYPE == "I2C") || (BUS_TYPE == "SPI"))) begin : g_cfg_err
      $error("bus_seq_fetcher: unsupported parameter set");
   end

   logic [1:0]                state_q, state_d;
   logic [ROM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ROM_ADDR_WIDTH-1:0] addr_q;
   logic                      pend_q;
   logic                      ptr_ovf_q, ptr_ovf_d;
   logic                      error_q, error_d;

   logic                      issue, squash, done;
   logic                      fifo_push, fifo_pop, fifo_flush, fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic [ROM_DATA_WIDTH-1:0] fifo_head;
   logic [CNT_W:0]            occ;
   opcode_e                   op;
   logic [ARG_W-1:0]          arg;

   assign op  = opcode_e'(bus_if.rom_data_i[ROM_DATA_WIDTH-1 -: OPC_W]);
   assign arg = bus_if.rom_data_i[ARG_W-1:0];
   assign occ = {1'b0, fifo_count} + (CNT_W+1)'(pend_q);

   // Squashing is done by withholding this cycle's issue, so at most one word
   // (the one being decoded now) is ever in flight.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ptr_ovf_d  = ptr_ovf_q;
      error_d    = error_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      squash     = 1'b0;
      done       = 1'b0;
      issue      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               ptr_d     = start_addr_i;
               ptr_ovf_d = 1'b0;
               error_d   = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (abort_i) begin
               fifo_flush = 1'b1;
               squash     = 1'b1;
               state_d    = ST_IDLE;
            end else if (pend_q) begin
               if (op == OP_JUMP) begin
                  squash    = 1'b1;
                  ptr_d     = arg[ROM_ADDR_WIDTH-1:0];
                  ptr_ovf_d = 1'b0;
               end else if (op == OP_END) begin
                  squash  = 1'b1;
                  state_d = ST_DRAIN;
               end else if (addr_q == ADDR_MAX) begin
                  error_d    = 1'b1;
                  fifo_flush = 1'b1;
                  squash     = 1'b1;
                  state_d    = ST_IDLE;
               end else if (op != OP_NOP) begin
                  fifo_push = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (abort_i) begin
               fifo_flush = 1'b1;
               state_d    = ST_IDLE;
            end else if (fifo_empty) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      issue = (state_q == ST_FETCH) && !squash && !ptr_ovf_q && (occ < DEPTH_C);
      if (issue) begin
         ptr_d = ptr_q + ROM_ADDR_WIDTH'(1);
         if (ptr_q == ADDR_MAX) ptr_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         addr_q    <= '0;
         pend_q    <= 1'b0;
         ptr_ovf_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         pend_q    <= issue;
         ptr_ovf_q <= ptr_ovf_d;
         error_q   <= error_d;
         if (issue) addr_q <= ptr_q;
      end
   end

   bus_seq_cmd_fifo #(
      .WIDTH (ROM_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (bus_if.rom_data_i),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign fifo_pop = !fifo_empty && bus_if.cmd_ready_i;

   assign bus_if.rom_rden_o  = issue;
   assign bus_if.rom_addr_o  = issue ? ptr_q : addr_q;
   assign bus_if.cmd_valid_o = !fifo_empty;
   assign bus_if.cmd_op_o    = fifo_head[ROM_DATA_WIDTH-1 -: OPC_W];
   assign bus_if.cmd_arg_o   = fifo_head[ARG_W-1:0];

   assign ready_o = (state_q == ST_IDLE);
   assign done_o  = done;
   assign error_o = error_q;

endmodule

// File: tb/tb_bus_seq_fetcher.sv
// Directed bench for bus_seq_fetcher: table of ROM programs with expected
// command streams plus hand-written stall and abort sequences.
module tb_bus_seq_fetcher;
   import bus_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] start_addr_i = '0;
   logic       abort_i = 1'b0;
   logic       ready_o, done_o, error_o;

   bus_seq_fetcher_if #(.ROM_DATA_WIDTH(13), .ROM_ADDR_WIDTH(8)) bus ();

   bus_seq_fetcher #(
      .ROM_DATA_WIDTH (13),
      .ROM_ADDR_WIDTH (8),
      .FIFO_DEPTH     (4),
      .BUS_TYPE       ("I2C")
   ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start_i),
      .start_addr_i (start_addr_i),
      .abort_i      (abort_i),
      .ready_o      (ready_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .bus_if       (bus)
   );

   always #5 clk = ~clk;

   // ROM model: data one cycle after the read enable
   logic [12:0] rom [256];
   logic [12:0] rom_q = '0;
   always @(posedge clk) if (bus.rom_rden_o) rom_q <= rom[bus.rom_addr_o];
   assign bus.rom_data_i = rom_q;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int base     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [12:0] got[$];
   int          got_rel[$];
   int          done_cnt, done_rel, max_cnt, chk_rel, seen_addr;
   logic [7:0]  bad_addr;
   bit          bad_hit;

   always @(negedge clk) begin
      int rel;
      rel = cyc - base + 1;
      if (bus.cmd_valid_o && bus.cmd_ready_i) begin
         got.push_back({bus.cmd_op_o, bus.cmd_arg_o});
         got_rel.push_back(rel);
      end
      if (done_o) begin
         done_cnt = done_cnt + 1;
         done_rel = rel;
      end
      if (bus.rom_rden_o && bus.rom_addr_o == bad_addr) bad_hit = 1'b1;
      if (bus.rom_rden_o && rel == chk_rel) seen_addr = int'(bus.rom_addr_o);
      if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
   end

   function automatic logic [12:0] W(input opcode_e op, input int unsigned a);
      return {op, 10'(a)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic clear_mon(input logic [7:0] bad, input int crel);
      got.delete();
      got_rel.delete();
      done_cnt  = 0;
      done_rel  = -1;
      max_cnt   = 0;
      bad_addr  = bad;
      bad_hit   = 1'b0;
      chk_rel   = crel;
      seen_addr = -1;
   endtask

   task automatic start_seq(input logic [7:0] a);
      @(posedge clk); #1;
      start_i = 1'b1;
      start_addr_i = a;
      @(posedge clk); #1;
      start_i = 1'b0;
      base = cyc;
   endtask

   task automatic wait_ready(output bit to);
      to = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready_o) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0]        start;
      int                n;
      logic [7:0][12:0]  exp;
      int                first;
      int                drel;
      logic              err;
      logic [7:0]        bad;
      int                crel;
      int                caddr;
   } vec_t;

   localparam int NV = 5;
   vec_t v [NV];

   initial begin : main
      bit to;
      logic [31:0] g;

      for (int a = 0; a < 256; a++) rom[a] = W(OP_END, 0);
      rom[8'h10] = W(OP_START, 0);
      rom[8'h11] = W(OP_WRITE, 'hA5);
      rom[8'h12] = W(OP_STOP, 0);
      rom[8'h13] = W(OP_END, 0);
      rom[8'h14] = W(OP_WRITE, 'h77);
      rom[8'h20] = W(OP_JUMP, 'h40);
      rom[8'h21] = W(OP_WRITE, 'h11);
      rom[8'h40] = W(OP_WRITE, 'h22);
      rom[8'h41] = W(OP_END, 0);
      for (int a = 'h50; a < 'h53; a++) rom[a] = W(OP_NOP, 3);
      rom[8'h53] = W(OP_END, 0);
      rom[8'h60] = W(OP_READ, 'h07);
      rom[8'h61] = W(OP_DELAY, 'h3FF);
      rom[8'h62] = W(OP_END, 0);
      for (int a = 0; a < 10; a++) rom['h80 + a] = W(OP_WRITE, 'h80 + a);
      rom[8'h8A] = W(OP_END, 0);
      for (int a = 0; a < 6; a++) rom['h90 + a] = W(OP_WRITE, 'h90 + a);
      rom[8'h96] = W(OP_END, 0);
      for (int a = 'hF8; a < 256; a++) rom[a] = W(OP_WRITE, a);

      v[0] = '{start:8'h10, n:3, exp:'0, first:3, drel:6, err:1'b0, bad:8'h14, crel:1, caddr:'h10};
      v[0].exp[0] = W(OP_START, 0);
      v[0].exp[1] = W(OP_WRITE, 'hA5);
      v[0].exp[2] = W(OP_STOP, 0);
      v[1] = '{start:8'hF8, n:7, exp:'0, first:3, drel:-1, err:1'b1, bad:8'h00, crel:8, caddr:'hFF};
      for (int j = 0; j < 7; j++) v[1].exp[j] = W(OP_WRITE, 'hF8 + j);
      v[2] = '{start:8'h20, n:1, exp:'0, first:5, drel:6, err:1'b0, bad:8'h42, crel:3, caddr:'h40};
      v[2].exp[0] = W(OP_WRITE, 'h22);
      v[3] = '{start:8'h50, n:0, exp:'0, first:0, drel:6, err:1'b0, bad:8'h54, crel:4, caddr:'h53};
      v[4] = '{start:8'h60, n:2, exp:'0, first:3, drel:5, err:1'b0, bad:8'h63, crel:2, caddr:'h61};
      v[4].exp[0] = W(OP_READ, 'h07);
      v[4].exp[1] = W(OP_DELAY, 'h3FF);

      bus.cmd_ready_i = 1'b1;
      clear_mon(8'h00, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_error", 32'(error_o), 0);
      chk("rst_rden", 32'(bus.rom_rden_o), 0);
      chk("rst_addr", 32'(bus.rom_addr_o), 0);
      chk("rst_valid", 32'(bus.cmd_valid_o), 0);

      for (int i = 0; i < NV; i++) begin
         clear_mon(v[i].bad, v[i].crel);
         start_seq(v[i].start);
         wait_ready(to);
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_timeout", i), 32'(to), 0);
         chk($sformatf("v%0d_ncmd", i), 32'(got.size()), 32'(v[i].n));
         for (int j = 0; j < v[i].n; j++) begin
            g = (j < got.size()) ? 32'(got[j]) : 32'hDEAD_BEEF;
            chk($sformatf("v%0d_cmd%0d", i, j), g, 32'(v[i].exp[j]));
            g = (j < got_rel.size()) ? 32'(got_rel[j]) : 32'hDEAD_BEEF;
            chk($sformatf("v%0d_cyc%0d", i, j), g, 32'(v[i].first + j));
         end
         chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), v[i].err ? 0 : 1);
         if (!v[i].err) chk($sformatf("v%0d_done_cyc", i), 32'(done_rel), 32'(v[i].drel));
         chk($sformatf("v%0d_error", i), 32'(error_o), 32'(v[i].err));
         chk($sformatf("v%0d_valid_idle", i), 32'(bus.cmd_valid_o), 0);
         chk($sformatf("v%0d_bad_read", i), 32'(bad_hit), 0);
         chk($sformatf("v%0d_read_addr", i), 32'(seen_addr), 32'(v[i].caddr));
      end

      // engine stall over 10 commands
      bus.cmd_ready_i = 1'b0;
      clear_mon(8'h8B, 0);
      start_seq(8'h80);
      repeat (30) @(negedge clk);
      chk("stall_valid", 32'(bus.cmd_valid_o), 1);
      chk("stall_head", 32'({bus.cmd_op_o, bus.cmd_arg_o}), 32'(W(OP_WRITE, 'h80)));
      chk("stall_ready", 32'(ready_o), 0);
      chk("stall_max_cnt", 32'(max_cnt), 4);
      @(posedge clk); #1;
      bus.cmd_ready_i = 1'b1;
      wait_ready(to);
      repeat (3) @(negedge clk);
      chk("stall_timeout", 32'(to), 0);
      chk("stall_ncmd", 32'(got.size()), 10);
      for (int j = 0; j < 10; j++) begin
         g = (j < got.size()) ? 32'(got[j]) : 32'hDEAD_BEEF;
         chk($sformatf("stall_cmd%0d", j), g, 32'(W(OP_WRITE, 'h80 + j)));
      end
      chk("stall_done", 32'(done_cnt), 1);
      chk("stall_max_cnt_end", 32'(max_cnt), 4);
      chk("stall_bad_read", 32'(bad_hit), 0);

      // abort with 3 queued and a read in flight (cycle 5)
      bus.cmd_ready_i = 1'b0;
      clear_mon(8'h00, 5);
      start_seq(8'h90);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_pre_valid", 32'(bus.cmd_valid_o), 1);
      chk("abort_pre_cnt", 32'(u_dut.fifo_count), 3);
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(bus.cmd_valid_o), 0);
      chk("abort_ready", 32'(ready_o), 1);
      repeat (5) @(negedge clk);
      chk("abort_done", 32'(done_cnt), 0);
      chk("abort_error", 32'(error_o), 0);
      chk("abort_ncmd", 32'(got.size()), 0);

      // restart after abort delivers a clean stream
      bus.cmd_ready_i = 1'b1;
      clear_mon(8'h14, 0);
      start_seq(8'h10);
      wait_ready(to);
      repeat (3) @(negedge clk);
      chk("post_abort_timeout", 32'(to), 0);
      chk("post_abort_ncmd", 32'(got.size()), 3);
      g = (got.size() > 0) ? 32'(got[0]) : 32'hDEAD_BEEF;
      chk("post_abort_cmd0", g, 32'(W(OP_START, 0)));
      chk("post_abort_done", 32'(done_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
